// File: rtl/mem_bus_arbiter_if.sv
// Bundles the two requester ports and the RAM-side signals of the main memory
// arbiter. The slave modport is the arbiter's view; master is the environment
// (requesters plus RAM) driving it.
interface mem_bus_arbiter_if #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32
);
   logic              req0;
   logic              req1;
   logic              we0;
   logic              we1;
   logic [ADDR_W-1:0] addr0;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata0;
   logic [DATA_W-1:0] wdata1;
   logic              gnt0;
   logic              gnt1;
   logic              done0;
   logic              done1;
   logic [DATA_W-1:0] rdata0;
   logic [DATA_W-1:0] rdata1;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              busy;

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
      output gnt0, gnt1, done0, done1, rdata0, rdata1,
             mem_en, mem_we, mem_addr, mem_wdata, busy
   );

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
      input  gnt0, gnt1, done0, done1, rdata0, rdata1,
             mem_en, mem_we, mem_addr, mem_wdata, busy
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter in front of the single-port main RAM. Port 0 is the CPU
// memory path, port 1 the loader / debug DMA. One access at a time: latch the
// winner's request, strobe the RAM for one cycle, wait MEM_LAT cycles, return
// read data with a one-cycle done pulse, then go back to IDLE.
module mem_bus_arbiter #(
   parameter int ADDR_W     = 9,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = 1,
   parameter int FIXED_PRIO = 0
) (
   input  logic               clk,
   input  logic               reset_n,
   mem_bus_arbiter_if.slave   bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Counter is reloaded with MEM_LAT-1 so that done lands MEM_LAT edges
   // after the RAM sampled the strobe (legal MEM_LAT is 1..15).
   localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

   state_t            state_q;
   logic [3:0]        cnt_q;
   logic              owner_q;
   logic              rr_last_q;
   logic              gnt0_q;
   logic              gnt1_q;
   logic              done0_q;
   logic              done1_q;
   logic              mem_en_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic [DATA_W-1:0] rdata0_q;
   logic [DATA_W-1:0] rdata1_q;
   logic              busy_q;
   logic              win_d;

   // Winner for a grant taken this cycle: lone requester wins; on a tie either
   // port 0 (fixed) or the port that did not win the previous tie.
   always_comb begin
      win_d = 1'b0;
      if (bus.req0 && bus.req1) begin
         win_d = (FIXED_PRIO != 0) ? 1'b0 : ~rr_last_q;
      end else if (bus.req1) begin
         win_d = 1'b1;
      end
   end

   // Arbitration FSM; every output is a register updated here.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= 4'd0;
         owner_q     <= 1'b0;
         rr_last_q   <= 1'b1;
         gnt0_q      <= 1'b0;
         gnt1_q      <= 1'b0;
         done0_q     <= 1'b0;
         done1_q     <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.req0 || bus.req1) begin
                  owner_q     <= win_d;
                  gnt0_q      <= ~win_d;
                  gnt1_q      <= win_d;
                  mem_en_q    <= 1'b1;
                  mem_we_q    <= win_d ? bus.we1 : bus.we0;
                  mem_addr_q  <= win_d ? bus.addr1 : bus.addr0;
                  mem_wdata_q <= win_d ? bus.wdata1 : bus.wdata0;
                  busy_q      <= 1'b1;
                  // Only a contested grant moves the round-robin pointer.
                  if (bus.req0 && bus.req1) begin
                     rr_last_q <= win_d;
                  end
                  state_q <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               // RAM samples the strobe on this edge; drop it immediately.
               mem_en_q <= 1'b0;
               cnt_q    <= LAT_M1;
               state_q  <= S_WAIT;
            end
            S_WAIT: begin
               if (cnt_q != 4'd0) begin
                  cnt_q <= cnt_q - 4'd1;
               end else begin
                  if (!mem_we_q) begin
                     if (owner_q) begin
                        rdata1_q <= bus.mem_rdata;
                     end else begin
                        rdata0_q <= bus.mem_rdata;
                     end
                  end
                  done0_q <= ~owner_q;
                  done1_q <= owner_q;
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               // Requests are ignored here so a port that drops req on seeing
               // done cannot be granted a second time.
               done0_q <= 1'b0;
               done1_q <= 1'b0;
               gnt0_q  <= 1'b0;
               gnt1_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.gnt0      = gnt0_q;
   assign bus.gnt1      = gnt1_q;
   assign bus.done0     = done0_q;
   assign bus.done1     = done1_q;
   assign bus.rdata0    = rdata0_q;
   assign bus.rdata1    = rdata1_q;
   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: instance A (round-robin, MEM_LAT=1) and instance
// B (fixed priority, MEM_LAT=4), each with a small synchronous RAM model.
module tb_mem_bus_arbiter;

   logic clk;
   logic reset_n;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   mem_bus_arbiter_if #(.ADDR_W(9), .DATA_W(32)) ifa ();
   mem_bus_arbiter_if #(.ADDR_W(9), .DATA_W(32)) ifb ();

   mem_bus_arbiter #(.ADDR_W(9), .DATA_W(32), .MEM_LAT(1), .FIXED_PRIO(0)) dut_a (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (ifa)
   );

   mem_bus_arbiter #(.ADDR_W(9), .DATA_W(32), .MEM_LAT(4), .FIXED_PRIO(1)) dut_b (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (ifb)
   );

   // Requester drive, routed to the selected instance only.
   logic        sel_b;
   logic        r_req0, r_req1, r_we0, r_we1;
   logic [8:0]  r_addr0, r_addr1;
   logic [31:0] r_wd0, r_wd1;

   assign ifa.req0 = r_req0 & ~sel_b;
   assign ifa.req1 = r_req1 & ~sel_b;
   assign ifb.req0 = r_req0 & sel_b;
   assign ifb.req1 = r_req1 & sel_b;
   assign ifa.we0 = r_we0;   assign ifb.we0 = r_we0;
   assign ifa.we1 = r_we1;   assign ifb.we1 = r_we1;
   assign ifa.addr0 = r_addr0; assign ifb.addr0 = r_addr0;
   assign ifa.addr1 = r_addr1; assign ifb.addr1 = r_addr1;
   assign ifa.wdata0 = r_wd0; assign ifb.wdata0 = r_wd0;
   assign ifa.wdata1 = r_wd1; assign ifb.wdata1 = r_wd1;

   // RAM models with a one-cycle registered read that holds its output.
   logic [31:0] ram_a [0:511];
   logic [31:0] ram_b [0:511];
   logic        pl_en, pl_b;
   logic [8:0]  pl_addr;
   logic [31:0] pl_data;

   always @(posedge clk) begin
      if (pl_en && !pl_b) ram_a[pl_addr] <= pl_data;
      else if (ifa.mem_en) begin
         if (ifa.mem_we) ram_a[ifa.mem_addr] <= ifa.mem_wdata;
         else            ifa.mem_rdata <= ram_a[ifa.mem_addr];
      end
   end

   always @(posedge clk) begin
      if (pl_en && pl_b) ram_b[pl_addr] <= pl_data;
      else if (ifb.mem_en) begin
         if (ifb.mem_we) ram_b[ifb.mem_addr] <= ifb.mem_wdata;
         else            ifb.mem_rdata <= ram_b[ifb.mem_addr];
      end
   end

   // Observed outputs of the selected instance.
   logic        m_gnt0, m_gnt1, m_done0, m_done1, m_mem_en, m_mem_we, m_busy;
   logic [8:0]  m_mem_addr;
   logic [31:0] m_mem_wdata, m_rdata0, m_rdata1;

   assign m_gnt0      = sel_b ? ifb.gnt0      : ifa.gnt0;
   assign m_gnt1      = sel_b ? ifb.gnt1      : ifa.gnt1;
   assign m_done0     = sel_b ? ifb.done0     : ifa.done0;
   assign m_done1     = sel_b ? ifb.done1     : ifa.done1;
   assign m_mem_en    = sel_b ? ifb.mem_en    : ifa.mem_en;
   assign m_mem_we    = sel_b ? ifb.mem_we    : ifa.mem_we;
   assign m_busy      = sel_b ? ifb.busy      : ifa.busy;
   assign m_mem_addr  = sel_b ? ifb.mem_addr  : ifa.mem_addr;
   assign m_mem_wdata = sel_b ? ifb.mem_wdata : ifa.mem_wdata;
   assign m_rdata0    = sel_b ? ifb.rdata0    : ifa.rdata0;
   assign m_rdata1    = sel_b ? ifb.rdata1    : ifa.rdata1;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b, expected %b", nm, act, exp);
      end
   endtask

   task automatic preload(input logic b, input logic [8:0] a, input logic [31:0] d);
      @(negedge clk);
      pl_en = 1'b1; pl_b = b; pl_addr = a; pl_data = d;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   typedef struct {
      logic        port;
      logic        we;
      logic [8:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
   } vec_t;

   // One complete single-requester transaction on the selected instance.
   task automatic txn(input vec_t v, input int idx);
      int    lat;
      string p;
      lat = sel_b ? 4 : 1;
      p = $sformatf("row%0d", idx);
      if (v.port) begin
         r_req1 = 1'b1; r_we1 = v.we; r_addr1 = v.addr; r_wd1 = v.wdata;
      end else begin
         r_req0 = 1'b1; r_we0 = v.we; r_addr0 = v.addr; r_wd0 = v.wdata;
      end
      @(negedge clk);
      chk1({p, " gnt_own"}, v.port ? m_gnt1 : m_gnt0, 1'b1);
      chk1({p, " gnt_other"}, v.port ? m_gnt0 : m_gnt1, 1'b0);
      chk1({p, " mem_en"}, m_mem_en, 1'b1);
      chk1({p, " mem_we"}, m_mem_we, v.we);
      chk({p, " mem_addr"}, {23'd0, m_mem_addr}, {23'd0, v.addr});
      chk({p, " mem_wdata"}, m_mem_wdata, v.wdata);
      @(negedge clk);
      chk1({p, " mem_en_low"}, m_mem_en, 1'b0);
      for (int k = 2; k <= lat; k++) begin
         @(negedge clk);
         chk1({p, " early_done"}, v.port ? m_done1 : m_done0, 1'b0);
      end
      @(negedge clk);
      chk1({p, " done"}, v.port ? m_done1 : m_done0, 1'b1);
      chk1({p, " gnt_other_d"}, v.port ? m_gnt0 : m_gnt1, 1'b0);
      chk({p, " rdata"}, v.port ? m_rdata1 : m_rdata0, v.exp_rd);
      r_req0 = 1'b0; r_req1 = 1'b0;
      @(negedge clk);
      chk1({p, " done_clear"}, v.port ? m_done1 : m_done0, 1'b0);
      chk1({p, " gnt_clear"}, v.port ? m_gnt1 : m_gnt0, 1'b0);
      chk1({p, " busy_clear"}, m_busy, 1'b0);
   endtask

   // Both ports held requesting; exp_order[i] is the port of the i-th grant.
   // Port 0's request is dropped when the drop0_at-th done is seen.
   task automatic run_both(input int n, input int drop0_at, input logic [3:0] exp_order,
                           input string tag);
      int   grants, dones, budget, dw0, dw1;
      logic pg0, pg1;
      grants = 0; dones = 0; budget = 0; dw0 = 0; dw1 = 0; pg0 = 1'b0; pg1 = 1'b0;
      r_req0 = 1'b1; r_req1 = 1'b1; r_we0 = 1'b0; r_we1 = 1'b0;
      r_addr0 = 9'h010; r_addr1 = 9'h011;
      while (dones < n && budget < 200) begin
         @(negedge clk);
         budget++;
         chk1({tag, " gnt_excl"}, m_gnt0 & m_gnt1, 1'b0);
         if (m_gnt0 && !pg0) begin
            if (grants < 4) chk1($sformatf("%s order%0d", tag, grants), 1'b0, exp_order[grants]);
            grants++;
         end
         if (m_gnt1 && !pg1) begin
            if (grants < 4) chk1($sformatf("%s order%0d", tag, grants), 1'b1, exp_order[grants]);
            grants++;
         end
         if (m_done0) dw0++;
         else if (dw0 != 0) begin chk({tag, " done0_width"}, 32'(dw0), 32'd1); dw0 = 0; end
         if (m_done1) dw1++;
         else if (dw1 != 0) begin chk({tag, " done1_width"}, 32'(dw1), 32'd1); dw1 = 0; end
         if (m_done0 || m_done1) begin
            dones++;
            if (dones == drop0_at) r_req0 = 1'b0;
         end
         pg0 = m_gnt0; pg1 = m_gnt1;
      end
      chk({tag, " txn_count"}, 32'(dones), 32'(n));
      r_req0 = 1'b0; r_req1 = 1'b0;
      @(negedge clk);
      chk1({tag, " last_done_width"}, m_done0 | m_done1, 1'b0);
      repeat (6) @(negedge clk);
      chk1({tag, " idle"}, m_busy, 1'b0);
   endtask

   vec_t tbl [8];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{1'b0, 1'b0, 9'h010, 32'h0000_0000, 32'hDEAD_BEEF};
      tbl[1] = '{1'b1, 1'b1, 9'h1FF, 32'h1234_5678, 32'h0000_0000};
      tbl[2] = '{1'b1, 1'b0, 9'h1FF, 32'h0000_0000, 32'h1234_5678};
      tbl[3] = '{1'b0, 1'b1, 9'h000, 32'hA5A5_A5A5, 32'hDEAD_BEEF};
      tbl[4] = '{1'b0, 1'b0, 9'h000, 32'h0000_0000, 32'hA5A5_A5A5};
      tbl[5] = '{1'b1, 1'b0, 9'h010, 32'h0000_0000, 32'hDEAD_BEEF};
      tbl[6] = '{1'b0, 1'b1, 9'h1FF, 32'h0000_0000, 32'hA5A5_A5A5};
      tbl[7] = '{1'b1, 1'b0, 9'h1FF, 32'h0000_0000, 32'h0000_0000};

      sel_b = 1'b0; reset_n = 1'b0;
      r_req0 = 1'b0; r_req1 = 1'b0; r_we0 = 1'b0; r_we1 = 1'b0;
      r_addr0 = '0; r_addr1 = '0; r_wd0 = '0; r_wd1 = '0;
      pl_en = 1'b0; pl_b = 1'b0; pl_addr = '0; pl_data = '0;

      preload(1'b0, 9'h010, 32'hDEAD_BEEF);
      preload(1'b0, 9'h011, 32'h1111_2222);
      preload(1'b1, 9'h010, 32'hDEAD_BEEF);
      preload(1'b1, 9'h011, 32'h1111_2222);
      preload(1'b1, 9'h020, 32'hCAFE_F00D);
      preload(1'b1, 9'h021, 32'h0BAD_F00D);

      chk("reset ctl A", {25'd0, ifa.gnt0, ifa.gnt1, ifa.done0, ifa.done1, ifa.mem_en,
                          ifa.mem_we, ifa.busy}, 32'd0);
      chk("reset ctl B", {25'd0, ifb.gnt0, ifb.gnt1, ifb.done0, ifb.done1, ifb.mem_en,
                          ifb.mem_we, ifb.busy}, 32'd0);
      chk("reset rdata0 A", ifa.rdata0, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // First tie after reset goes to port 0; then reset lands mid-WAIT.
      r_req0 = 1'b1; r_req1 = 1'b1; r_we0 = 1'b0; r_we1 = 1'b1;
      r_addr0 = 9'h010; r_wd0 = 32'h55AA_55AA; r_addr1 = 9'h011; r_wd1 = 32'h7777_7777;
      @(negedge clk);
      chk1("first tie gnt0", m_gnt0, 1'b1);
      chk1("first tie gnt1", m_gnt1, 1'b0);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("abort ctl", {25'd0, m_gnt0, m_gnt1, m_done0, m_done1, m_mem_en, m_mem_we, m_busy},
          32'd0);
      chk("abort mem_addr", {23'd0, m_mem_addr}, 32'd0);
      chk("abort mem_wdata", m_mem_wdata, 32'd0);
      chk("abort rdata0", m_rdata0, 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk1("abort no done0", m_done0, 1'b0);
      end
      reset_n = 1'b1;
      @(negedge clk);
      chk1("tie after reset gnt0", m_gnt0, 1'b1);
      chk1("tie after reset gnt1", m_gnt1, 1'b0);
      @(negedge clk);
      @(negedge clk);
      chk1("tie after reset done0", m_done0, 1'b1);
      chk("tie after reset rdata0", m_rdata0, 32'hDEAD_BEEF);
      r_req0 = 1'b0; r_req1 = 1'b0;
      @(negedge clk);
      chk1("tie after reset idle", m_busy, 1'b0);

      // Directed single transactions on the round-robin instance.
      do_reset();
      for (int i = 0; i < 8; i++) txn(tbl[i], i);

      do_reset();
      run_both(4, 99, 4'b1010, "rr");

      sel_b = 1'b1;
      run_both(4, 3, 4'b1000, "fixed");

      // MEM_LAT=4 read; port 1 raised while port 0 is in WAIT.
      r_req0 = 1'b1; r_we0 = 1'b0; r_addr0 = 9'h020;
      r_req1 = 1'b0; r_we1 = 1'b0; r_addr1 = 9'h021;
      for (int k = 0; k <= 13; k++) begin
         @(negedge clk);
         chk1($sformatf("lat k%0d gnt0", k), m_gnt0, k <= 5);
         chk1($sformatf("lat k%0d done0", k), m_done0, k == 5);
         chk1($sformatf("lat k%0d gnt1", k), m_gnt1, (k >= 7) && (k <= 12));
         chk1($sformatf("lat k%0d done1", k), m_done1, k == 12);
         if (k == 2) r_req1 = 1'b1;
         if (k == 5) begin
            chk("lat rdata0", m_rdata0, 32'hCAFE_F00D);
            r_req0 = 1'b0;
         end
         if (k == 12) begin
            chk("lat rdata1", m_rdata1, 32'h0BAD_F00D);
            r_req1 = 1'b0;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
